// File: rtl/time_display.sv
// Display-side reader of the minute/second counter: samples once per scan frame,
// converts to BCD sequentially and multiplexes a 4-digit common-anode MM.SS display.
module time_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] second,
  input  logic [5:0] minute,
  output logic [6:0] seg,
  output logic [3:0] dig_sel,
  output logic       dp,
  output logic       hold
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if (SCAN_DIV < 8) begin : g_bad_scan_div
    $error("time_display: SCAN_DIV must be at least 8 so a conversion fits inside one digit");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } conv_state_t;

  // ---------------------------------------------------------------------------
  // Scan engine
  // ---------------------------------------------------------------------------
  logic [CW-1:0] scan_cnt;
  logic [1:0]    dig_idx;
  logic          scan_wrap;
  logic          frame_start;
  logic          frame_end;

  assign scan_wrap   = (scan_cnt == CW'(SCAN_DIV - 1));
  // The edge that enters digit 3 is the snapshot edge; the edge leaving it ends the frame.
  assign frame_start = scan_wrap && (dig_idx == 2'd2);
  assign frame_end   = scan_wrap && (dig_idx == 2'd3);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion engine: shift-add-3, both fields in parallel.
  // Shift register layout: {tens[13:10], units[9:6], binary[5:0]}.
  // ---------------------------------------------------------------------------
  function automatic logic [13:0] add3_shift(input logic [13:0] v);
    logic [13:0] a;
    a = v;
    if (a[13:10] >= 4'd5) a[13:10] = a[13:10] + 4'd3;
    if (a[9:6]   >= 4'd5) a[9:6]   = a[9:6]   + 4'd3;
    return {a[12:0], 1'b0};
  endfunction

  conv_state_t state;
  logic [5:0]  snap_s;
  logic [5:0]  snap_m;
  logic [13:0] sh_s;
  logic [13:0] sh_m;
  logic [2:0]  iter;
  logic [7:0]  pending_s;
  logic [7:0]  pending_m;
  logic        pending_hold;

  // NOTE: every register here, including snapshot and pending storage, is reset
  // so that a reset mid-conversion leaves no stale result to leak onto the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      snap_s       <= '0;
      snap_m       <= '0;
      sh_s         <= '0;
      sh_m         <= '0;
      iter         <= '0;
      pending_s    <= '0;
      pending_m    <= '0;
      pending_hold <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            snap_s <= second;
            snap_m <= minute;
            state  <= LOAD;
          end
        end
        LOAD: begin
          sh_s  <= {8'd0, snap_s};
          sh_m  <= {8'd0, snap_m};
          iter  <= 3'd0;
          state <= SHIFT;
        end
        SHIFT: begin
          sh_s <= add3_shift(sh_s);
          sh_m <= add3_shift(sh_m);
          if (iter == 3'd5) begin
            state <= DONE;
          end else begin
            iter <= iter + 3'd1;
          end
        end
        DONE: begin
          pending_s    <= sh_s[13:6];
          pending_m    <= sh_m[13:6];
          pending_hold <= (snap_m >= 6'd60);
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display registers and output encoding
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  logic [7:0] disp_s;
  logic [7:0] disp_m;
  logic [7:0] next_disp_s;
  logic [7:0] next_disp_m;
  logic       next_hold;
  logic [1:0] next_idx;
  logic [3:0] next_nib;

  // With SCAN_DIV == 8 the DONE edge coincides with the frame end, so the fresh
  // result is forwarded straight into the display instead of via pending.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_disp_s = disp_s;
    next_disp_m = disp_m;
    next_hold   = hold;
    next_idx    = scan_wrap ? (dig_idx + 2'd1) : dig_idx;
    if (frame_end) begin
      if (state == DONE) begin
        next_disp_s = sh_s[13:6];
        next_disp_m = sh_m[13:6];
        next_hold   = (snap_m >= 6'd60);
      end else begin
        next_disp_s = pending_s;
        next_disp_m = pending_m;
        next_hold   = pending_hold;
      end
    end
    case (next_idx)
      2'd0:    next_nib = next_disp_s[3:0];
      2'd1:    next_nib = next_disp_s[7:4];
      2'd2:    next_nib = next_disp_m[3:0];
      default: next_nib = next_disp_m[7:4];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_s  <= '0;
      disp_m  <= '0;
      hold    <= 1'b0;
      seg     <= 7'b1000000;
      dig_sel <= 4'b1110;
      dp      <= 1'b1;
    end else begin
      disp_s  <= next_disp_s;
      disp_m  <= next_disp_m;
      hold    <= next_hold;
      seg     <= seg_encode(next_nib);
      dig_sel <= ~(4'b0001 << next_idx);
      dp      <= (next_idx != 2'd2);
    end
  end

endmodule

// File: tb/tb_time_display.sv
// Self-checking bench for time_display (SCAN_DIV=8): every cycle the outputs are
// compared with a frame-level model built from a history of applied inputs.
module tb_time_display;

  localparam int SCAN_DIV = 8;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] second = '0;
  logic [5:0] minute = '0;
  logic [6:0] seg;
  logic [3:0] dig_sel;
  logic       dp;
  logic       hold;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n = 0;
  string       phase = "init";
  logic [11:0] hist [0:8191];
  logic [3:0]  sel_tbl [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  time_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .second  (second),
    .minute  (minute),
    .seg     (seg),
    .dig_sel (dig_sel),
    .dp      (dp),
    .hold    (hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h expected %0h (n=%0d t=%0t)", phase, tag, got, exp, n, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Display after n edges shows the inputs present just before the snapshot
  // edge of the previous frame; nothing before the first full frame.
  task automatic check_outputs();
    int          idx, s, m, d;
    logic [11:0] v;
    idx = (n / SCAN_DIV) % 4;
    if (n < FRAME) begin
      s = 0;
      m = 0;
    end else begin
      v = hist[FRAME * (n / FRAME) - SCAN_DIV - 1];
      m = int'(v[11:6]);
      s = int'(v[5:0]);
    end
    case (idx)
      0:       d = s % 10;
      1:       d = s / 10;
      2:       d = m % 10;
      default: d = m / 10;
    endcase
    check("seg", seg, seg_of(d));
    check("dig_sel", dig_sel, sel_tbl[idx]);
    check("dp", dp, (idx == 2) ? 1'b0 : 1'b1);
    check("hold", hold, (m >= 60));
  endtask

  task automatic step(input logic [5:0] m, input logic [5:0] s);
    check_outputs();
    minute  = m;
    second  = s;
    hist[n] = {m, s};
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    check("rst_seg", seg, 7'b1000000);
    check("rst_dig_sel", dig_sel, 4'b1110);
    check("rst_dp", dp, 1'b1);
    check("rst_hold", hold, 1'b0);
  endtask

  // Called at a negedge: asserts reset mid-cycle, checks the asynchronous
  // response before any clock edge, then releases on the next negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
  endtask

  task automatic run_random(input int cycles, input int change_pct);
    logic [5:0] m, s;
    m = minute;
    s = second;
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(99, 0) < change_pct) begin
        m = ($urandom_range(3, 0) == 0) ? 6'($urandom_range(63, 58)) : 6'($urandom_range(63, 0));
        s = 6'($urandom_range(63, 0));
      end
      step(m, s);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;

    phase = "reset_mid_frame";
    run_random(20, 50);
    do_reset();

    phase = "static_12_37";
    for (int i = 0; i < 2 * FRAME; i++) step(6'd12, 6'd37);

    phase = "coherence";
    for (int i = 0; i < 2 * FRAME && (n % FRAME) != 3 * SCAN_DIV + 3; i++) step(6'd4, 6'd59);
    for (int i = 0; i < 2 * FRAME; i++) step(6'd5, 6'd0);

    phase = "terminal_60";
    for (int i = 0; i < 2 * FRAME; i++) step(6'd60, 6'd0);

    phase = "reset_mid_conv";
    for (int i = 0; i < 2 * FRAME && (n % FRAME) != 3 * SCAN_DIV + 3; i++) step(6'd33, 6'd44);
    do_reset();
    run_random(3 * FRAME, 100);

    phase = "rotation";
    for (int i = 0; i < 2 * FRAME; i++) step(6'd9, 6'd8);

    phase = "random";
    run_random(600, 25);
    run_random(200, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_display.md
# time_display

Display-side consumer for the minute/second counter. Samples the counter's binary `second` and `minute` outputs once per scan frame and converts them to BCD with a sequential shift-add-3 engine. Drives a 4-digit multiplexed common-anode seven-segment display showing MM.SS. It sits between the counter and the board pins, and is the reader of the counter's output interface.

## Interface

Parameters:
- `SCAN_DIV`, default 1000: clock cycles each digit stays selected. Legal range is ≥ 8; smaller values are illegal.

Ports (clock and reset first):
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `second` input 6: binary seconds from the counter, 0..63 accepted.
- `minute` input 6: binary minutes from the counter, 0..63 accepted.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low.
- `dig_sel` output 4: digit enables, active-low, one-hot-low. Bit 0 = seconds units, bit 1 = seconds tens, bit 2 = minutes units, bit 3 = minutes tens.
- `dp` output 1: decimal point, active-low. Lit only while digit 2 is selected (the MM.SS separator).
- `hold` output 1: high while the displayed minute value is ≥ 60 (counter terminal state).

Clocking and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.

## Operation

**Scan engine**
- `scan_cnt` counts 0..SCAN_DIV-1 and then wraps.
- On wrap, `dig_idx` advances 0→1→2→3→0.
- `dig_sel` = ~(1 << `dig_idx`).
- `seg` shows the selected display nibble, encoded active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other nibble = 1111111 (blank).
- `seg`, `dig_sel` and `dp` are registered outputs.

**Conversion FSM** (IDLE, LOAD, SHIFT, DONE)
- IDLE → LOAD on the first cycle of digit 3 (`dig_idx`==3, `scan_cnt`==0).
  - `second` and `minute` are captured into snapshot registers on that edge.
- LOAD: clears the BCD scratch and loads the shift registers (1 cycle).
- SHIFT: 6 cycles, with both fields processed in parallel. Each cycle:
  - every BCD nibble ≥ 5 gets +3;
  - then {bcd, bin} shifts left by 1.
  - A 3-bit iteration counter runs 0..5.
- DONE: writes the results to `pending_s[7:0]`, `pending_m[7:0]` and `pending_hold`; 1 cycle, then returns to IDLE.
- Total is 8 cycles, which always completes inside digit 3 because SCAN_DIV ≥ 8.
- On the wrap from digit 3 to digit 0, the display registers load from the pending registers. The four digits are therefore always coherent within one frame.
- Input changes after the snapshot edge are ignored until the next frame.
- Arithmetic: the 6-bit input gives a 2-nibble BCD result, with tens 0..6 and units 0..9. No clamping is applied; 60..63 display literally.

**Reset** (asynchronous, any state including mid-conversion)
- `scan_cnt`=0, `dig_idx`=0, FSM=IDLE; snapshot, pending and display registers = 0.
- Output reset values: `seg`=1000000, `dig_sel`=1110, `dp`=1, `hold`=0.
- Any conversion in progress is discarded.

## Timing

- One frame = 4·SCAN_DIV cycles. Each digit is selected for exactly SCAN_DIV consecutive cycles. `dig_sel` is never all-ones and never has two zeros.
- Input-to-display latency: a value sampled at the start of digit 3 appears at the start of the next digit 0, i.e. SCAN_DIV cycles later.
- After reset release, the first display update occurs at cycle 4·SCAN_DIV. Until then the display shows 00.00.
- `hold` changes only on the digit 3→0 wrap, together with the display registers.
- `seg`, `dig_sel` and `dp` change on the same edge as `dig_idx`.

## Test plan

All scenarios use SCAN_DIV=8.

1. **Reset values:** assert `rst_n`=0 mid-frame → outputs go asynchronously to `seg`=1000000, `dig_sel`=1110, `dp`=1, `hold`=0. Release reset → `dig_sel` stays 1110 for 8 cycles.
2. **Static value:** hold `minute`=12, `second`=37 → in the second frame:
   - digit 0 `seg`=1111000 (7);
   - digit 1 `seg`=0110000 (3);
   - digit 2 `seg`=0100100 (2) with `dp`=0;
   - digit 3 `seg`=1111001 (1).
3. **Snapshot coherence:** with inputs 04/59, change to 05/00 at cycle 3 of digit 3 → the next frame shows 04.59 on every digit, and the following frame shows 05.00. Mixed digits never appear.
4. **Terminal state:** `minute`=60, `second`=0 → the frame shows 60.00. Digit 3 `seg`=0000010, and `hold`=1 from the digit-0 edge of that frame.
5. **Reset mid-conversion:** pulse `rst_n` low during SHIFT → the display reverts to 00.00 and the pending result is lost. The next full frame shows the freshly sampled inputs.
6. **Scan rotation:** over 64 cycles, `dig_sel` cycles 1110, 1101, 1011, 0111 at exactly 8 cycles each. `dp`=0 only during the 1011 windows.
